// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle between the PC generator and its neighbours
// Ports (signals): stall, instr_ready, branch_taken/branch_target,
//   trap_redirect/trap_target driven by the master; pc, fetch_valid and
//   misalign_exc driven back by the slave (pc_gen).
interface pc_gen_if;
  logic        stall;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_redirect;
  logic [31:0] trap_target;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        misalign_exc;
  modport master (
    output stall, instr_ready, branch_taken, branch_target, trap_redirect, trap_target,
    input  pc, fetch_valid, misalign_exc
  );
  modport slave (
    input  stall, instr_ready, branch_taken, branch_target, trap_redirect, trap_target,
    output pc, fetch_valid, misalign_exc
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter generator with sequential advance, stall, and prioritised trap/branch redirects
// Ports: clk, rst_n (async, active-low), bus (pc_gen_if.slave: stall, instr_ready,
//   branch/trap redirect requests and targets in; pc, fetch_valid, misalign_exc out).
// Optional macro PC_MISALIGN_CHECK_EN enables the misaligned-target pulse on misalign_exc.
module pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);
  typedef enum logic [1:0] {BOOT, RUN, WAIT, PEND} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_target_q, pend_target_d;
  logic        pend_trap_q, pend_trap_d;
  logic        redir, active;
  logic [31:0] raw_tgt, redir_tgt;
  always_comb begin
    redir     = bus.trap_redirect | bus.branch_taken;
    raw_tgt   = bus.trap_redirect ? bus.trap_target : bus.branch_target;
    redir_tgt = raw_tgt & 32'hFFFF_FFFC;
    active    = (state_q == RUN) || (state_q == WAIT);
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_trap_d   = pend_trap_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, WAIT: begin
        if (redir) begin
          if (bus.instr_ready) begin
            pc_d    = redir_tgt;
            state_d = RUN;
          end else begin
            // the outstanding fetch must drain before the redirect takes effect
            pend_target_d = redir_tgt;
            pend_trap_d   = bus.trap_redirect;
            state_d       = PEND;
          end
        end else if (bus.instr_ready) begin
          state_d = RUN;
          pc_d    = bus.stall ? pc_q : pc_q + 32'd4;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        // a latched trap cannot be displaced by a later branch
        if (bus.trap_redirect) begin
          pend_target_d = redir_tgt;
          pend_trap_d   = 1'b1;
        end else if (bus.branch_taken && !pend_trap_q) begin
          pend_target_d = redir_tgt;
        end
        if (bus.instr_ready) begin
          pc_d        = pend_target_d;
          pend_trap_d = 1'b0;
          state_d     = RUN;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR & 32'hFFFF_FFFC;
      pend_target_q <= 32'h0;
      pend_trap_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_trap_q   <= pend_trap_d;
    end
  end
  assign bus.pc          = pc_q;
  assign bus.fetch_valid = active & bus.instr_ready & ~redir;
`ifdef PC_MISALIGN_CHECK_EN
  assign bus.misalign_exc = active & redir & (|raw_tgt[1:0]);
`else
  assign bus.misalign_exc = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen with directed scenarios and randomized traffic
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h0000_1000;
`ifdef PC_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        mis;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pc_gen_if bus();
  pc_gen #(.RESET_VECTOR(RV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  logic        m_boot, m_pend, m_pend_trap;
  logic [31:0] m_pc, m_pend_addr;
  task automatic drive(input logic s, input logic ir, input logic br, input logic [31:0] bt,
                       input logic tr, input logic [31:0] tt);
    bus.stall = s; bus.instr_ready = ir; bus.branch_taken = br;
    bus.branch_target = bt; bus.trap_redirect = tr; bus.trap_target = tt;
  endtask
  task automatic chk(input logic [31:0] p, input logic f, input string n);
    if (bus.pc !== p || bus.fetch_valid !== f) begin
      miscompares++;
      $display("FAIL %s: got pc=%h fetch_valid=%b, expected pc=%h fetch_valid=%b",
               n, bus.pc, bus.fetch_valid, p, f);
    end
  endtask
  task automatic cyc(input logic s, input logic ir, input logic br, input logic [31:0] bt,
                     input logic tr, input logic [31:0] tt);
    exp_t e;
    logic [31:0] tgt;
    drive(s, ir, br, bt, tr, tt);
    e.pc = m_pc; e.fv = 1'b0; e.mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_pend) begin
      tgt  = tr ? tt : bt;
      e.fv = ir && !(tr || br);
      e.mis = MIS && (tr || br) && (tgt[1:0] != 2'b00);
      if (tr || br) begin
        if (ir) m_pc = {tgt[31:2], 2'b00};
        else begin
          m_pend = 1'b1; m_pend_addr = {tgt[31:2], 2'b00}; m_pend_trap = tr;
        end
      end else if (ir && !s) m_pc = m_pc + 32'd4;
    end else begin
      if (tr) begin
        m_pend_addr = {tt[31:2], 2'b00}; m_pend_trap = 1'b1;
      end else if (br && !m_pend_trap) m_pend_addr = {bt[31:2], 2'b00};
      if (ir) begin
        m_pc = m_pend_addr; m_pend = 1'b0; m_pend_trap = 1'b0;
      end
    end
    q.push_back(e);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    exp_t e;
    rst_n = 1'b0;
    drive($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom,
          $urandom_range(1), $urandom);
    e.pc = RV; e.fv = 1'b0; e.mis = 1'b0;
    q.push_back(e);
    m_boot = 1'b1; m_pend = 1'b0; m_pend_trap = 1'b0; m_pc = RV; m_pend_addr = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (bus.pc !== e.pc || bus.fetch_valid !== e.fv || bus.misalign_exc !== e.mis) begin
        miscompares++;
        $display("FAIL vec%0d: got pc=%h fetch_valid=%b misalign_exc=%b, expected pc=%h fetch_valid=%b misalign_exc=%b",
                 vectors, bus.pc, bus.fetch_valid, bus.misalign_exc, e.pc, e.fv, e.mis);
      end
    end
  end
  initial begin
    logic [31:0] bt, tt;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();
    chk(RV, 1'b0, "reset state");
    repeat (4) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h10, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk(32'h10, 1'b0, "wait hold");
    cyc(0, 1, 0, 0, 0, 0);
    chk(32'h14, 1'b1, "wait expiry");
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h20, 0, 0);
    cyc(0, 0, 1, 32'h100, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h200);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h40, 1, 32'h80);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h102, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h300, 0, 0);
    cyc(0, 0, 1, 32'h303, 0, 0);
    do_reset();
    cyc(0, 1, 1, 32'h500, 1, 32'h600);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else begin
        bt = $urandom; tt = $urandom;
        if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
        if ($urandom_range(3) != 0) tt[1:0] = 2'b00;
        cyc($urandom_range(99) < 30, $urandom_range(99) < 70, $urandom_range(99) < 15, bt,
            $urandom_range(99) < 8, tt);
      end
    end
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
